// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC frame streamer.
// Contents: word width, the stall/drop mode encoding and the sequencer
// FSM state encoding.
package adc_stream_pkg;

    localparam int WORD_W = 32;

    // Backpressure policy applied to the word currently on the push bus.
    typedef enum logic {
        MODE_DROP  = 1'b0,   // advance every cycle, count beats not accepted
        MODE_STALL = 1'b1    // hold the word until push_ready
    } stall_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/adc_frame_stream_seq_if.sv
// Word push bus from the frame sequencer to its consumer.
// Signals: push_valid, push_data (one 32-bit word), push_last (final word
// of a frame), push_ready (consumer acceptance).
// Handshake: a beat transfers on a rising edge where push_valid and
// push_ready are both high. In hold mode the source keeps push_valid,
// push_data and push_last stable until the transfer; in drop mode the source
// advances every cycle and a beat seen with push_ready low is lost.
interface adc_frame_stream_seq_if;
    import adc_stream_pkg::*;

    logic              push_valid;
    logic [WORD_W-1:0] push_data;
    logic              push_last;
    logic              push_ready;

    modport master (output push_valid, push_data, push_last, input push_ready);
    modport slave  (input push_valid, push_data, push_last, output push_ready);
endinterface

// File: rtl/adc_frame_queue.sv
// Synchronous FIFO holding whole frames waiting behind the active one.
// Ports: clk/rst (sync, active-high), push + push_data, pop, head_data
// (combinational view of the oldest entry), level, full, empty.
// Push and pop may coincide, including when full: the head is read before
// the edge and the freed slot is written at that same edge.
module adc_frame_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 288
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);

endmodule

// File: rtl/adc_frame_stream_seq.sv
// ADC frame streamer: captures whole frames on a one-cycle strobe, keeps
// the first WORDS_OUT words, and pushes them out one word per beat.
// Ports: clk/rst (sync, active-high); frame_valid + frame_words_packed
// (word k at [32k+31:32k]); stall_mode (0 drop, 1 hold); clear_counters;
// push_if (word push bus, master side); busy, q_level (frames waiting behind
// the active one), frame_dropped pulse, saturating frames_dropped_cnt and
// words_dropped_cnt; state_dbg exposes the sequencer FSM state.
module adc_frame_stream_seq
    import adc_stream_pkg::*;
#(
    parameter int WORDS_IN  = 10,
    parameter int WORDS_OUT = 9,
    parameter int QDEPTH    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_valid,
    input  logic [WORD_W*WORDS_IN-1:0]    frame_words_packed,
    input  logic                          stall_mode,
    input  logic                          clear_counters,
    adc_frame_stream_seq_if.master        push_if,
    output logic                          busy,
    output logic [$clog2(QDEPTH):0]       q_level,
    output logic                          frame_dropped,
    output logic [CNT_W-1:0]              frames_dropped_cnt,
    output logic [CNT_W-1:0]              words_dropped_cnt,
    output state_e                        state_dbg
);
    localparam int FW = WORD_W * WORDS_OUT;
    localparam int IW = (WORDS_OUT > 1) ? $clog2(WORDS_OUT) : 1;

    state_e        state_q, state_d;
    stall_mode_e   mode_q, mode_d;
    logic [FW-1:0] cur_q, cur_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          fdrop_q, fdrop_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d, wcnt_q, wcnt_d;

    logic          q_push, q_pop, q_full, q_empty;
    logic [FW-1:0] q_head;

    logic          active, is_last, retire, last_ret, fv;
    logic [FW-1:0] frame_in;
    logic          unused_frame_bits;

    // Only the leading WORDS_OUT words are kept; the rest are ignored.
    assign frame_in          = frame_words_packed[FW-1:0];
    assign unused_frame_bits = ^frame_words_packed;

    assign active   = (state_q == ST_ACTIVE);
    assign is_last  = (idx_q == IW'(WORDS_OUT - 1));
    assign retire   = active && ((mode_q == MODE_DROP) || push_if.push_ready);
    assign last_ret = retire && is_last;
    assign fv       = frame_valid && !rst;

    adc_frame_queue #(.DEPTH(QDEPTH), .W(FW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (frame_in),
        .pop       (q_pop),
        .head_data (q_head),
        .level     (q_level),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        fdrop_d = 1'b0;
        fcnt_d  = fcnt_q;
        wcnt_d  = wcnt_q;
        q_push  = 1'b0;
        q_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Queue is always empty here; a frame goes straight to active.
                mode_d = stall_mode_e'(stall_mode);
                if (fv) begin
                    cur_d   = frame_in;
                    idx_d   = '0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (retire) begin
                    // Mode changes are picked up only when a new word starts.
                    mode_d = stall_mode_e'(stall_mode);
                    if (is_last) begin
                        idx_d = '0;
                        if (!q_empty) begin
                            q_pop = 1'b1;
                            cur_d = q_head;
                        end else if (fv) begin
                            // Empty queue: the arriving frame follows with no bubble.
                            cur_d = frame_in;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (fv && !(last_ret && q_empty)) begin
                    // A same-cycle pop frees the slot even when full.
                    if (!q_full || last_ret) begin
                        q_push = 1'b1;
                    end else begin
                        fdrop_d = 1'b1;
                        if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
                    end
                end
                if ((mode_q == MODE_DROP) && !push_if.push_ready && (wcnt_q != '1))
                    wcnt_d = wcnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_counters) begin
            fcnt_d = '0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_DROP;
            cur_q   <= '0;
            idx_q   <= '0;
            fdrop_q <= 1'b0;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            fdrop_q <= fdrop_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign push_if.push_valid = active;
    assign push_if.push_data  = active ? cur_q[int'(idx_q)*WORD_W +: WORD_W] : '0;
    assign push_if.push_last  = active && is_last;
    assign busy               = active || (q_level != '0);
    assign frame_dropped      = fdrop_q;
    assign frames_dropped_cnt = fcnt_q;
    assign words_dropped_cnt  = wcnt_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_adc_frame_stream_seq.sv
// Bench for adc_frame_stream_seq: directed scenarios plus a randomized run,
// every cycle compared against a frame-queue reference model.
module tb_adc_frame_stream_seq;
    import adc_stream_pkg::*;

    localparam int WI   = 10;
    localparam int WO   = 9;
    localparam int QD   = 4;
    localparam int CW   = 4;
    localparam int LW   = $clog2(QD) + 1;
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_valid = 1'b0;
    logic [32*WI-1:0] frame_words_packed = '0;
    logic             stall_mode = 1'b1;
    logic             clear_counters = 1'b0;
    logic             busy, frame_dropped;
    logic [LW-1:0]    q_level;
    logic [CW-1:0]    fcnt, wcnt;
    state_e           state_dbg;

    adc_frame_stream_seq_if push_if();

    adc_frame_stream_seq #(.WORDS_IN(WI), .WORDS_OUT(WO), .QDEPTH(QD), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_valid        (frame_valid),
        .frame_words_packed (frame_words_packed),
        .stall_mode         (stall_mode),
        .clear_counters     (clear_counters),
        .push_if            (push_if),
        .busy               (busy),
        .q_level            (q_level),
        .frame_dropped      (frame_dropped),
        .frames_dropped_cnt (fcnt),
        .words_dropped_cnt  (wcnt),
        .state_dbg          (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // frames[0] is the frame on the bus, the rest are waiting.
    logic [32*WO-1:0] frames[$];
    logic [31:0]      exp_q[$];
    int               m_idx, m_fcnt, m_wcnt;
    logic             m_mode, m_fdrop;

    int   tests_run = 0, tests_failed = 0;
    int   hs_beats, valid_beats, frames_done, drop_pulses;
    logic [31:0] last_word;
    logic saw_a9;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [31:0] pre_data);
        bit active, retire, last_ret, accept;
        if (rst) begin
            frames.delete();
            exp_q.delete();
            m_idx = 0; m_fcnt = 0; m_wcnt = 0; m_fdrop = 1'b0; m_mode = 1'b0;
            return;
        end
        active   = frames.size() > 0;
        retire   = active && (!m_mode || push_if.push_ready);
        last_ret = retire && (m_idx == WO - 1);
        accept   = frame_valid && (!active || (frames.size() - 1 < QD) || last_ret);
        m_fdrop  = frame_valid && !accept;
        if (active && !m_mode && !push_if.push_ready && m_wcnt < CMAX) m_wcnt++;
        if (m_fdrop && m_fcnt < CMAX) m_fcnt++;
        if (clear_counters) begin m_fcnt = 0; m_wcnt = 0; end
        if (!active || retire) m_mode = stall_mode;
        if (retire) begin
            check_eq("beat_data", pre_data, exp_q.pop_front());
            if (last_ret) begin
                void'(frames.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (accept) begin
            frames.push_back(frame_words_packed[32*WO-1:0]);
            for (int k = 0; k < WO; k++) exp_q.push_back(frame_words_packed[32*k +: 32]);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        logic [31:0] ed;
        ev = frames.size() > 0;
        ed = 32'h0;
        if (ev) ed = frames[0][m_idx*32 +: 32];
        check_eq("push_valid", push_if.push_valid, ev);
        check_eq("push_data", push_if.push_data, ed);
        check_eq("push_last", push_if.push_last, ev && (m_idx == WO - 1));
        check_eq("busy", busy, ev);
        check_eq("q_level", q_level, ev ? frames.size() - 1 : 0);
        check_eq("frame_dropped", frame_dropped, m_fdrop);
        check_eq("frames_dropped_cnt", fcnt, m_fcnt);
        check_eq("words_dropped_cnt", wcnt, m_wcnt);
        check_eq("state_dbg", state_dbg, ev ? ST_ACTIVE : ST_IDLE);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        logic [31:0] pre_data;
        logic pv, pr, pl;
        pre_data = push_if.push_data;
        pv = push_if.push_valid;
        pr = push_if.push_ready;
        pl = push_if.push_last;
        if (pv === 1'b1) begin
            valid_beats++;
            if (pre_data == 32'hA9) saw_a9 = 1'b1;
            if (pr) begin
                hs_beats++;
                if (pl) begin frames_done++; last_word = pre_data; end
            end
        end
        @(posedge clk);
        model_edge(pre_data);
        #1;
        check_outputs();
        if (frame_dropped === 1'b1) drop_pulses++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_stats();
        hs_beats = 0; valid_beats = 0; frames_done = 0; drop_pulses = 0;
        last_word = '0; saw_a9 = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        frame_valid = 1'b1;   // must be ignored while in reset
        frame_words_packed = {WI{32'h5555_AAAA}};
        run(2);
        rst = 1'b0;
        frame_valid = 1'b0;
        clear_counters = 1'b0;
        clear_stats();
    endtask

    task automatic send(input logic [32*WI-1:0] f);
        frame_words_packed = f;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
    endtask

    function automatic logic [32*WI-1:0] make_seq(input logic [31:0] base);
        logic [32*WI-1:0] r;
        for (int k = 0; k < WI; k++) r[32*k +: 32] = base + 32'(k);
        return r;
    endfunction

    function automatic logic [32*WI-1:0] rand_frame();
        logic [32*WI-1:0] r;
        for (int k = 0; k < WI; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- scenarios ----------------
    initial begin
        push_if.push_ready = 1'b1;
        reset_dut();
        check_eq("rst_push_valid", push_if.push_valid, 0);
        check_eq("rst_q_level", q_level, 0);
        check_eq("rst_fcnt", fcnt, 0);

        // Single frame, consumer always ready.
        stall_mode = 1'b1;
        send(make_seq(32'hA0));
        check_eq("s1_word0", push_if.push_data, 32'hA0);
        run(12);
        check_eq("s1_beats", hs_beats, 9);
        check_eq("s1_last_word", last_word, 32'hA8);
        check_eq("s1_no_a9", saw_a9, 0);

        // Hold mode: word 3 held through 5 not-ready cycles.
        reset_dut();
        stall_mode = 1'b1;
        push_if.push_ready = 1'b1;
        send(make_seq(32'hB0));
        run(3);
        push_if.push_ready = 1'b0;
        repeat (5) begin
            step();
            check_eq("s2_hold", push_if.push_data, 32'hB3);
        end
        push_if.push_ready = 1'b1;
        run(10);
        check_eq("s2_beats", hs_beats, 9);
        check_eq("s2_fcnt", fcnt, 0);
        check_eq("s2_wcnt", wcnt, 0);

        // Drop mode: 3 beats not accepted.
        reset_dut();
        stall_mode = 1'b0;
        push_if.push_ready = 1'b1;
        send(make_seq(32'hD0));
        run(2);
        push_if.push_ready = 1'b0;
        run(3);
        push_if.push_ready = 1'b1;
        run(8);
        check_eq("s3_beats", valid_beats, 9);
        check_eq("s3_wcnt", wcnt, 3);

        // Seven back-to-back frames while stalled.
        reset_dut();
        stall_mode = 1'b1;
        push_if.push_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(rand_frame());
        push_if.push_ready = 1'b1;
        run(50);
        check_eq("s4_frames", frames_done, 5);
        check_eq("s4_pulses", drop_pulses, 2);
        check_eq("s4_fcnt", fcnt, 2);

        // Frame arrives on a full queue as the last word retires.
        reset_dut();
        stall_mode = 1'b1;
        push_if.push_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(rand_frame());
        push_if.push_ready = 1'b1;
        run(8);
        check_eq("s5_full", q_level, 4);
        send(rand_frame());
        check_eq("s5_q_level", q_level, 4);
        check_eq("s5_no_drop", frame_dropped, 0);
        check_eq("s5_fcnt", fcnt, 0);
        run(60);
        check_eq("s5_frames", frames_done, 6);

        // Reset mid-frame with two frames waiting.
        reset_dut();
        stall_mode = 1'b1;
        push_if.push_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_frame());
        push_if.push_ready = 1'b1;
        run(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("s6_valid", push_if.push_valid, 0);
        check_eq("s6_q_level", q_level, 0);
        check_eq("s6_busy", busy, 0);
        send(make_seq(32'hC0));
        check_eq("s6_restart", push_if.push_data, 32'hC0);
        run(12);

        // Counter saturation and clear priority.
        reset_dut();
        stall_mode = 1'b1;
        push_if.push_ready = 1'b0;
        for (int i = 0; i < 24; i++) send(rand_frame());
        check_eq("sat_fcnt", fcnt, CMAX);
        clear_counters = 1'b1;
        send(rand_frame());
        clear_counters = 1'b0;
        check_eq("clr_fcnt", fcnt, 0);
        check_eq("clr_pulse", frame_dropped, 1);
        push_if.push_ready = 1'b1;
        run(60);
        reset_dut();
        stall_mode = 1'b0;
        push_if.push_ready = 1'b0;
        send(rand_frame());
        send(rand_frame());
        run(25);
        check_eq("sat_wcnt", wcnt, CMAX);

        // Randomized traffic.
        reset_dut();
        repeat (4000) begin
            frame_valid = ($urandom_range(0, 5) == 0);
            if (frame_valid) frame_words_packed = rand_frame();
            push_if.push_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) stall_mode = ~stall_mode;
            clear_counters = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        frame_valid = 1'b0;
        rst = 1'b0;
        clear_counters = 1'b0;
        push_if.push_ready = 1'b1;
        run(80);
        check_eq("end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adc_frame_stream_seq.md
ADC_FRAME_STREAM_SEQ -- requirements
Module: adc_frame_stream_seq

Interface
REQ-001 SHALL have parameter WORDS_IN, default 10: 32-bit words per input frame.
REQ-002 SHALL have parameter WORDS_OUT, default 9: words pushed per frame, 1..WORDS_IN, lowest first.
REQ-003 SHALL have parameter QDEPTH, default 4: queued frames behind the active one, power of 2, >=1.
REQ-004 SHALL have parameter CNT_W, default 16: width of drop counters.
REQ-005 SHALL have input clk, 1 bit: clock, all logic rising-edge.
REQ-006 SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have input frame_valid, 1 bit: one-cycle frame strobe.
REQ-008 SHALL have input frame_words_packed, 32*WORDS_IN bits: word k at [32k+31:32k].
REQ-009 SHALL have input stall_mode, 1 bit: 0 = drop-on-full, 1 = hold on backpressure.
REQ-010 SHALL have input clear_counters, 1 bit: synchronous clear of drop counters.
REQ-011 SHALL have outputs push_valid (1), push_data (32), push_last (1, final word of frame) and input push_ready (1).
REQ-012 SHALL have outputs busy (1), q_level ($clog2(QDEPTH)+1), frame_dropped (1-cycle pulse), frames_dropped_cnt (CNT_W) and words_dropped_cnt (CNT_W).

Function
REQ-013 SHALL latch only words 0..WORDS_OUT-1 of each accepted frame.
REQ-014 SHALL, when idle with an empty queue, load frame_valid at cycle T as active, with push_valid=1 and word0 at T+1.
REQ-015 SHALL, when active, write an incoming frame to the queue tail if q_level<QDEPTH or a pop occurs the same cycle.
REQ-016 SHALL otherwise drop the frame, pulse frame_dropped next cycle and increment frames_dropped_cnt.
REQ-017 SHALL, in stall_mode=1, advance the word index only on push_valid&&push_ready and hold push_data stable otherwise.
REQ-018 SHALL, in stall_mode=0, advance one word per active cycle; each beat with push_ready=0 increments words_dropped_cnt.
REQ-019 SHALL assert push_last with the WORDS_OUT-1 word and retire that word per REQ-017/018.
REQ-020 SHALL, on retiring the last word, pop the queue head and present its word0 next cycle with no bubble; if the queue is empty, deassert push_valid.
REQ-021 SHALL take stall_mode changes effect at the next word boundary only.
REQ-022 SHALL make both counters saturate at all-ones and never wrap.
REQ-023 SHALL give clear_counters priority over a same-cycle increment, with the counters reading 0 next cycle.
REQ-024 SHALL drive busy = active or q_level!=0, and q_level = queued frames excluding the active one.
REQ-025 SHALL implement the FSM as IDLE -> ACTIVE on accept, ACTIVE -> ACTIVE on last-word retire with queue non-empty, and ACTIVE -> IDLE on last-word retire with queue empty.

Reset
REQ-026 SHALL, with rst high, discard the active and queued frames mid-operation and force push_valid=0, push_last=0, push_data=0, busy=0, q_level=0, frame_dropped=0 and both counters 0 in the next cycle.
REQ-027 SHALL ignore frame_valid in any cycle where rst is high.

Structure
REQ-028 SHALL place the word width (32), the stall/drop mode encoding and the FSM state encoding in shared package adc_stream_pkg.
REQ-029 SHALL implement the queue as sub-module adc_frame_queue, a synchronous FIFO QDEPTH x 32*WORDS_OUT with same-cycle push/pop.

Verification
REQ-030 SHALL cover: a single frame of words 0xA0..0xA9 with push_ready=1 -> 9 beats 0xA0..0xA8 at T+1..T+9, push_last on 0xA8, and 0xA9 never pushed.
REQ-031 SHALL cover: stall_mode=1 with push_ready low for 5 cycles at word 3 -> word 3 held stable for 5 cycles, all 9 words delivered, counters 0.
REQ-032 SHALL cover: stall_mode=0 with push_ready low for 3 beats -> 9 beats, words_dropped_cnt=3.
REQ-033 SHALL cover: QDEPTH=4 with 7 frames back-to-back while stalled -> 5 delivered in order, 2 frame_dropped pulses, frames_dropped_cnt=2.
REQ-034 SHALL cover: a frame arriving with the queue full in the same cycle the last word retires -> accepted, q_level stays 4, no drop.
REQ-035 SHALL cover: rst asserted mid-frame with 2 frames queued -> next cycle push_valid=0, q_level=0, busy=0, and a post-reset frame restarts at word0.
